// File: rtl/poets_mem_arb_pkg.sv
// Shared types and defaults for the on-chip MLAB arbiter slice.
// No logic; latency n/a.
// Backpressure n/a.
package poets_mem_arb_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 32;

    typedef enum logic {
        ST_SERVE = 1'b0,
        ST_FILL  = 1'b1
    } state_t;

    typedef logic req_id_t;

    localparam req_id_t ID_M0 = 1'b0;
    localparam req_id_t ID_M1 = 1'b1;

    // Tag carried down the read-return pipe alongside each granted read.
    typedef struct packed {
        logic    vld;
        req_id_t id;
    } rd_tag_t;

endpackage

// File: rtl/poets_mem_rr_arb2.sv
// Two-way round-robin arbiter with last-grant memory.
// Latency: combinational grant; last_grant updates on the grant edge.
// Backpressure: en low suppresses all grants; losers simply see no grant.
module poets_mem_rr_arb2
    import poets_mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output req_id_t    grant_id
);

    req_id_t last_grant;
    logic    any_gnt;

    always_comb begin
        grant_id = ID_M0;
        if (req == 2'b11) begin
            grant_id = ~last_grant;
        end else if (req[1]) begin
            grant_id = ID_M1;
        end
        any_gnt = en & (|req);
        grant   = {any_gnt & grant_id, any_gnt & ~grant_id};
    end

    // Reset to m1 so m0 takes the very first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= ID_M1;
        end else if (any_gnt) begin
            last_grant <= grant_id;
        end
    end

endmodule

// File: rtl/poets_onchip_mem_arbiter.sv
// Shares one single-port MLAB between two Avalon-MM masters and adds a constant-fill sequencer.
// Latency: write lands on the grant edge; read data returns 2 cycles after grant; fill takes DEPTH cycles.
// Backpressure: waitrequest for the losing master and for both masters throughout a fill.
module poets_onchip_mem_arbiter
    import poets_mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_value,
    output logic              fill_busy,
    output logic              fill_done,

    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic              mem_debugaccess,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] fill_cnt, fill_cnt_nxt;
    logic [DATA_W-1:0] fill_val;
    logic              fill_active;
    logic              fill_last;

    logic [1:0]        req;
    logic [1:0]        grant;
    req_id_t           grant_id;
    logic              gnt_write;
    logic              gnt_read;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_wdata;

    logic [ADDR_W-1:0] addr_hold;
    logic [DATA_W-1:0] wdata_hold;
    logic              rd_push;
    rd_tag_t           rd_tag;

    assign req         = {m1_read | m1_write, m0_read | m0_write};
    assign fill_active = (state == ST_FILL);
    assign fill_last   = fill_active && (fill_cnt == LAST_ADDR);
    assign fill_busy   = fill_active;

    // Grants are blocked while in reset so any pending request sees waitrequest.
    poets_mem_rr_arb2 u_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (~fill_active & reset_n),
        .req      (req),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign m0_waitrequest = fill_active | (req[0] & ~grant[0]);
    assign m1_waitrequest = fill_active | (req[1] & ~grant[1]);

    assign gnt_write = (grant_id == ID_M1) ? m1_write     : m0_write;
    assign gnt_read  = (grant_id == ID_M1) ? m1_read      : m0_read;
    assign gnt_addr  = (grant_id == ID_M1) ? m1_address   : m0_address;
    assign gnt_wdata = (grant_id == ID_M1) ? m1_writedata : m0_writedata;

    always_comb begin
        state_nxt    = state;
        fill_cnt_nxt = fill_cnt;
        case (state)
            ST_SERVE: begin
                if (fill_start) begin
                    state_nxt    = ST_FILL;
                    fill_cnt_nxt = '0;
                end
            end
            ST_FILL: begin
                fill_cnt_nxt = fill_cnt + 1'b1;
                if (fill_last) begin
                    state_nxt = ST_SERVE;
                end
            end
            default: state_nxt = ST_SERVE;
        endcase
    end

    // A simultaneous read+write is treated as a write with no read return.
    always_comb begin
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_address    = addr_hold;
        mem_writedata  = wdata_hold;
        rd_push        = 1'b0;
        if (fill_active) begin
            mem_chipselect = 1'b1;
            mem_write      = 1'b1;
            mem_address    = fill_cnt;
            mem_writedata  = fill_val;
        end else if (|grant) begin
            mem_chipselect = 1'b1;
            mem_write      = gnt_write;
            mem_address    = gnt_addr;
            mem_writedata  = gnt_wdata;
            rd_push        = gnt_read & ~gnt_write;
        end
    end

    // The RAM only honours wren when debugaccess is set.
    assign mem_debugaccess = mem_write;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_SERVE;
            fill_cnt   <= '0;
            fill_val   <= '0;
            fill_done  <= 1'b0;
            addr_hold  <= '0;
            wdata_hold <= '0;
            rd_tag     <= '0;
        end else begin
            state      <= state_nxt;
            fill_cnt   <= fill_cnt_nxt;
            fill_done  <= fill_last;
            addr_hold  <= mem_address;
            wdata_hold <= mem_writedata;
            rd_tag     <= '{vld: rd_push, id: grant_id};
            if (!fill_active && fill_start) begin
                fill_val <= fill_value;
            end
        end
    end

    // Second pipe stage: RAM q is valid now, steer it to the requester.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m0_readdatavalid <= 1'b0;
            m1_readdatavalid <= 1'b0;
            m0_readdata      <= '0;
            m1_readdata      <= '0;
        end else begin
            m0_readdatavalid <= rd_tag.vld && (rd_tag.id == ID_M0);
            m1_readdatavalid <= rd_tag.vld && (rd_tag.id == ID_M1);
            if (rd_tag.vld && (rd_tag.id == ID_M0)) begin
                m0_readdata <= mem_readdata;
            end
            if (rd_tag.vld && (rd_tag.id == ID_M1)) begin
                m1_readdata <= mem_readdata;
            end
        end
    end

endmodule
